// File: rtl/sgn_div_pkg.sv
// Shared types and constants for the signed sequential divider.
package sgn_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_BW    = 8;
   localparam int DEF_CNT_W = $clog2(DEF_BW);

   function automatic int cnt_width(input int bw);
      return $clog2(bw);
   endfunction

   // Most-negative two's complement value of a bw-bit word, right-aligned.
   function automatic logic [63:0] most_neg(input int bw);
      return 64'd1 << (bw - 1);
   endfunction

endpackage

// File: rtl/sgn_div_step.sv
// One restoring division iteration on unsigned magnitudes.
module sgn_div_step #(
   parameter int BW = 8
) (
   input  logic [BW:0]   rem_in,
   input  logic [BW-1:0] dvsr,
   input  logic          dbit,
   output logic [BW:0]   rem_out,
   output logic          qbit
);

   logic [BW+1:0] shifted;
   logic [BW+1:0] diff;

   // A borrow out of the trial subtraction shows up as a set sign bit.
   always_comb begin
      shifted = {rem_in, dbit};
      diff    = shifted - {2'b00, dvsr};
      qbit    = ~diff[BW+1];
      rem_out = qbit ? diff[BW:0] : shifted[BW:0];
   end

endmodule

// File: rtl/sgn_div_seq.sv
// Signed radix-2 restoring divider with valid/ready handshakes on both sides.
module sgn_div_seq
   import sgn_div_pkg::*;
#(
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] dividend,
   input  logic [BW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] quotient,
   output logic [BW-1:0] remainder,
   output logic          div_zero,
   output logic          overflow
);

   localparam int            CW       = cnt_width(BW);
   localparam logic [63:0]   MIN_WIDE = most_neg(BW);
   localparam logic [BW-1:0] MIN_VAL  = MIN_WIDE[BW-1:0];

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          fin;
   logic [BW-1:0] dvd_mag, dvs_mag, dvd_raw, qacc;
   logic [BW:0]   prem, step_rem;
   logic          step_q;
   logic          sign_q, sign_r, dz_pend, ov_pend;

   function automatic logic [BW-1:0] mag(input logic [BW-1:0] v);
      return v[BW-1] ? -v : v;
   endfunction

   sgn_div_step #(.BW(BW)) u_step (
      .rem_in  (prem),
      .dvsr    (dvs_mag),
      .dbit    (dvd_mag[BW-1]),
      .rem_out (step_rem),
      .qbit    (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (fin) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // RUN spends BW edges iterating, then one more edge (fin set) on the sign fixup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         fin       <= 1'b0;
         dvd_mag   <= '0;
         dvs_mag   <= '0;
         dvd_raw   <= '0;
         qacc      <= '0;
         prem      <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dz_pend   <= 1'b0;
         ov_pend   <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd_mag <= mag(dividend);
                  dvs_mag <= mag(divisor);
                  dvd_raw <= dividend;
                  sign_q  <= dividend[BW-1] ^ divisor[BW-1];
                  sign_r  <= dividend[BW-1];
                  dz_pend <= (divisor == '0);
                  ov_pend <= (dividend == MIN_VAL) && (divisor == '1);
                  prem    <= '0;
                  qacc    <= '0;
                  cnt     <= CW'(BW - 1);
                  fin     <= 1'b0;
               end
            end
            RUN: begin
               if (!fin) begin
                  prem    <= step_rem;
                  qacc    <= {qacc[BW-2:0], step_q};
                  dvd_mag <= {dvd_mag[BW-2:0], 1'b0};
                  if (cnt == '0) fin <= 1'b1;
                  else           cnt <= cnt - CW'(1);
               end else if (dz_pend) begin
                  quotient  <= '1;
                  remainder <= dvd_raw;
                  div_zero  <= 1'b1;
                  overflow  <= 1'b0;
               end else if (ov_pend) begin
                  quotient  <= MIN_VAL;
                  remainder <= '0;
                  div_zero  <= 1'b0;
                  overflow  <= 1'b1;
               end else begin
                  quotient  <= sign_q ? -qacc : qacc;
                  remainder <= sign_r ? -prem[BW-1:0] : prem[BW-1:0];
                  div_zero  <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sgn_div_seq.sv
// Directed and randomised checks of sgn_div_seq at BW=8 against hand values and a reference model.
module tb_sgn_div_seq;

   localparam int BW = 8;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] dividend;
   logic [BW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] quotient;
   logic [BW-1:0] remainder;
   logic          div_zero;
   logic          overflow;

   int checks_total  = 0;
   int checks_passed = 0;

   sgn_div_seq #(.BW(BW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair, wait for acceptance, then count edges until out_valid.
   task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      if (!in_ready) checkOutput("in_ready_wait", 64'(in_ready), 64'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic runVector(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                            input logic [BW-1:0] eq, input logic [BW-1:0] er,
                            input logic edz, input logic eov);
      int lat;
      applyStimulus(a, b, lat);
      checkOutput({tag, "_lat"}, 64'(lat), 64'd9);
      checkOutput({tag, "_q"}, 64'(quotient), 64'(eq));
      checkOutput({tag, "_r"}, 64'(remainder), 64'(er));
      checkOutput({tag, "_flags"}, 64'({div_zero, overflow}), 64'({edz, eov}));
      drain();
   endtask

   initial begin
      int lat;
      logic saw_valid;
      logic [BW-1:0] ra, rb, rq, rr;
      logic rdz, rov;
      int sa, sb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_q", 64'(quotient), 64'd0);
      checkOutput("rst_r", 64'(remainder), 64'd0);
      checkOutput("rst_flags", 64'({div_zero, overflow}), 64'd0);
      rst_n = 1'b1;
      tick();

      runVector("p100_7",   8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0);
      runVector("n100_7",   8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0);
      runVector("p100_n7",  8'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0);
      runVector("n100_n7",  8'h9C,   8'hF9,   8'h0E, 8'hFE, 1'b0, 1'b0);
      runVector("div0",     8'd7,    8'h00,   8'hFF, 8'h07, 1'b1, 1'b0);
      runVector("min_n1",   8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1);
      runVector("min_1",    8'h80,   8'h01,   8'h80, 8'h00, 1'b0, 1'b0);
      runVector("max_min",  8'h7F,   8'h80,   8'h00, 8'h7F, 1'b0, 1'b0);
      runVector("min_min",  8'h80,   8'h80,   8'h01, 8'h00, 1'b0, 1'b0);
      runVector("small",    8'd5,    8'd9,    8'h00, 8'h05, 1'b0, 1'b0);
      runVector("n1_2",     8'hFF,   8'd2,    8'h00, 8'hFF, 1'b0, 1'b0);
      runVector("min_7",    8'h80,   8'd7,    8'hEE, 8'hFE, 1'b0, 1'b0);

      // Backpressure: hold the result while new operands are offered.
      applyStimulus(8'd100, 8'd7, lat);
      checkOutput("bp_lat", 64'(lat), 64'd9);
      dividend = 8'd36;
      divisor  = 8'd5;
      in_valid = 1'b1;
      repeat (5) tick();
      checkOutput("bp_hold_q", 64'(quotient), 64'h0E);
      checkOutput("bp_hold_r", 64'(remainder), 64'h02);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp_idle_valid", 64'(out_valid), 64'd0);
      checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("bp_accept", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("bp2_lat", 64'(lat), 64'd9);
      checkOutput("bp2_q", 64'(quotient), 64'd7);
      checkOutput("bp2_r", 64'(remainder), 64'd1);
      drain();

      // Reset in the middle of an iteration sequence.
      dividend = 8'd36;
      divisor  = 8'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_q", 64'(quotient), 64'd0);
      checkOutput("mid_rst_r", 64'(remainder), 64'd0);
      checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (20) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      checkOutput("mid_rst_no_valid", 64'(saw_valid), 64'd0);
      checkOutput("mid_rst_ready_after", 64'(in_ready), 64'd1);
      runVector("post_rst", 8'd36, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0);

      // Random pairs against a signed integer reference.
      for (int i = 0; i < 2000; i++) begin
         ra = 8'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 8'h00;
            1:       rb = 8'hFF;
            2:       begin ra = 8'h80; rb = 8'($urandom); end
            default: rb = 8'($urandom);
         endcase
         sa = int'($signed(ra));
         sb = int'($signed(rb));
         rdz = 1'b0;
         rov = 1'b0;
         if (sb == 0) begin
            rq = 8'hFF;
            rr = ra;
            rdz = 1'b1;
         end else if (sa == -128 && sb == -1) begin
            rq = 8'h80;
            rr = 8'h00;
            rov = 1'b1;
         end else begin
            rq = 8'(sa / sb);
            rr = 8'(sa % sb);
         end
         runVector("rand", ra, rb, rq, rr, rdz, rov);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
